// File: rtl/display_scan_ctrl.sv
`timescale 1ns/1ps
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   Each digit gets one slot of REFRESH_DIV cycles. The first GUARD_CYCLES
//   cycles of a slot are blanked so the previous digit's segments cannot
//   ghost onto the next anode. The 16-bit digit word is captured once per
//   frame, so a frame always shows one coherent time value. It also handles
//   per-digit blink and leading-zero blanking of the hours-tens digit.
//
//   The handshake-free interface uses level inputs sampled every cycle.
//   disp_en, blink_mask and lz_suppress affect blank one cycle later and
//   never stall or reset the scan.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   digits_in    in   16  BCD digits, [15:12]=hours tens .. [3:0]=minutes units
//   blink_mask   in   4   bit i=1: digit digits_in[4i+3:4i] blinks
//   lz_suppress  in   1   1: blank the hours-tens digit when it is 0
//   disp_en      in   1   0: force the display dark (scan keeps running)
//   sel          out  2   digit select, 0=leftmost .. 3=rightmost
//   bcd_out      out  4   BCD nibble for the selected digit (registered)
//   blank        out  1   1: all anodes off this cycle (registered)
//   frame_start  out  1   pulse in the last cycle of a frame (snapshot edge)
//   blink_phase  out  1   1: blinking digits are currently off
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1000,
  parameter int BLINK_DIV    = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic        lz_suppress,
  input  logic        disp_en,
  output logic [1:0]  sel,
  output logic [3:0]  bcd_out,
  output logic        blank,
  output logic        frame_start,
  output logic        blink_phase
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW:0]   GUARD_W = (PW + 1)'(GUARD_CYCLES);
  localparam logic [FW-1:0] FC_LAST = FW'(BLINK_DIV - 1);

  typedef enum logic {ST_GUARD, ST_SHOW} state_t;
  // With no guard interval the slot begins directly in SHOW.
  localparam state_t SLOT_START = (GUARD_CYCLES == 0) ? ST_SHOW : ST_GUARD;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [1:0]    sel_nx;
  logic [15:0]   snap, snap_nx;
  logic [FW-1:0] frame_cnt, frame_cnt_nx;
  logic          phase_nx;
  logic          tc, frame_end;
  logic [3:0]    bcd_nx;
  logic          blank_nx, fs_nx;
  logic [1:0]    mask_idx;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SLOT_START;
      presc       <= '0;
      sel         <= 2'd0;
      snap        <= 16'h0000;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      bcd_out     <= 4'h0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      presc       <= presc_nx;
      sel         <= sel_nx;
      snap        <= snap_nx;
      frame_cnt   <= frame_cnt_nx;
      blink_phase <= phase_nx;
      bcd_out     <= bcd_nx;
      blank       <= blank_nx;
      frame_start <= fs_nx;
    end
  end

  // Next-state: prescaler, slot FSM, digit select, snapshot, blink counter
  always_comb begin
    tc        = (presc == PS_LAST);
    frame_end = tc && (sel == 2'd3);
    presc_nx  = tc ? '0 : presc + 1'b1;
    sel_nx    = tc ? sel + 2'd1 : sel;
    snap_nx   = frame_end ? digits_in : snap;

    state_nx = state;
    case (state)
      ST_GUARD: begin
        if (tc)                              state_nx = SLOT_START;
        else if ({1'b0, presc_nx} == GUARD_W) state_nx = ST_SHOW;
      end
      ST_SHOW: begin
        if (tc) state_nx = SLOT_START;
      end
      default: state_nx = SLOT_START;
    endcase

    frame_cnt_nx = frame_cnt;
    phase_nx     = blink_phase;
    if (frame_end) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt_nx = '0;
        phase_nx     = ~blink_phase;
      end else begin
        frame_cnt_nx = frame_cnt + 1'b1;
      end
    end
  end

  // Output decode, computed from next-state values so that registered
  // bcd_out/blank/frame_start line up with sel in the same cycle.
  always_comb begin
    mask_idx = ~sel_nx;  // sel 0 (leftmost) maps to blink_mask[3]
    case (sel_nx)
      2'd0:    bcd_nx = snap_nx[15:12];
      2'd1:    bcd_nx = snap_nx[11:8];
      2'd2:    bcd_nx = snap_nx[7:4];
      default: bcd_nx = snap_nx[3:0];
    endcase
    blank_nx = (state_nx == ST_GUARD)
             | ~disp_en
             | (blink_mask[mask_idx] & phase_nx)
             | (lz_suppress & (sel_nx == 2'd0) & (snap_nx[15:12] == 4'h0));
    fs_nx    = (presc_nx == PS_LAST) && (sel_nx == 2'd3);
  end

endmodule
